// File: rtl/sm4_pkg.sv
// Shared SM4 constants and the sequencer state type.
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;
    localparam int SM4_RKW    = 32;
    localparam int SM4_CNT_W  = $clog2(SM4_ROUNDS);

    // System parameters XORed with the master key before expansion.
    localparam logic [31:0] FK0 = 32'hA3B1_BAC6;
    localparam logic [31:0] FK1 = 32'h56AA_3350;
    localparam logic [31:0] FK2 = 32'h677D_9197;
    localparam logic [31:0] FK3 = 32'hB270_22DC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_DRUN,
        ST_DFIN,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/sm4_rk_store.sv
// Round-key register file: one synchronous write port, one combinational read port.
module sm4_rk_store #(
    parameter int DEPTH = 32,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write one round key per cycle while the schedule is being expanded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so the key is available in the same round it is selected.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/sm4_round_ctrl.sv
// Sequencer for an iterative SM4 engine: key expansion, round-key storage,
// and 32-round encrypt/decrypt jobs with host and result handshakes.
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int ROUNDS = SM4_ROUNDS,
    parameter int RKW    = SM4_RKW
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic                      MK_VALID_i,
    output logic                      MK_READY_o,
    input  logic                      DAT_VALID_i,
    input  logic                      DEC_i,
    output logic                      DAT_READY_o,
    output logic                      RES_VALID_o,
    input  logic                      RES_READY_i,
    output logic                      KEY_VALID_o,
    output logic                      KEY_LOAD_o,
    output logic                      KEY_STEP_o,
    input  logic [RKW-1:0]            RK_i,
    output logic                      DAT_LOAD_o,
    output logic                      DAT_STEP_o,
    output logic                      DAT_FINAL_o,
    output logic [RKW-1:0]            RK_o,
    output logic [$clog2(ROUNDS)-1:0] ROUND_o
);

    localparam int            CW   = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            key_valid, key_valid_nxt;
    logic            dec_q, dec_nxt;
    logic            mk_rdy, dat_rdy;
    logic            rk_we;
    logic [CW-1:0]   rk_raddr;
    logic [RKW-1:0]  rk_rdata;

    sm4_rk_store #(
        .DEPTH (ROUNDS),
        .W     (RKW)
    ) u_rk_store (
        .clk   (CLK_i),
        .we    (rk_we),
        .waddr (cnt),
        .wdata (RK_i),
        .raddr (rk_raddr),
        .rdata (rk_rdata)
    );

    // State, round counter, schedule-valid flag and latched direction.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_valid <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_valid <= key_valid_nxt;
            dec_q     <= dec_nxt;
        end
    end

    // Next-state, handshakes, datapath strobes and round-key selection.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_valid_nxt = key_valid;
        dec_nxt       = dec_q;
        mk_rdy        = 1'b0;
        dat_rdy       = 1'b0;
        rk_we         = 1'b0;
        rk_raddr      = '0;
        RES_VALID_o   = 1'b0;
        KEY_LOAD_o    = 1'b0;
        KEY_STEP_o    = 1'b0;
        DAT_LOAD_o    = 1'b0;
        DAT_STEP_o    = 1'b0;
        DAT_FINAL_o   = 1'b0;
        RK_o          = '0;
        ROUND_o       = '0;

        case (state)
            ST_IDLE: begin
                // Readies are masked by reset so every output reads 0 while RST_i is high.
                mk_rdy  = ~RST_i;
                dat_rdy = key_valid & ~MK_VALID_i & ~RST_i;
                if (MK_VALID_i && mk_rdy) begin
                    KEY_LOAD_o    = 1'b1;
                    key_valid_nxt = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = ST_KEXP;
                end else if (DAT_VALID_i && dat_rdy) begin
                    DAT_LOAD_o = 1'b1;
                    dec_nxt    = DEC_i;
                    cnt_nxt    = '0;
                    state_nxt  = ST_DRUN;
                end
            end
            ST_KEXP: begin
                KEY_STEP_o = 1'b1;
                ROUND_o    = cnt;
                rk_we      = 1'b1;
                if (cnt == LAST) begin
                    cnt_nxt       = '0;
                    key_valid_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DRUN: begin
                DAT_STEP_o = 1'b1;
                ROUND_o    = cnt;
                rk_raddr   = dec_q ? (LAST - cnt) : cnt;
                RK_o       = rk_rdata;
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DFIN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DFIN: begin
                DAT_FINAL_o = 1'b1;
                state_nxt   = ST_HOLD;
            end
            ST_HOLD: begin
                RES_VALID_o = 1'b1;
                if (RES_READY_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign MK_READY_o  = mk_rdy;
    assign DAT_READY_o = dat_rdy;
    assign KEY_VALID_o = key_valid;

endmodule

// File: doc/sm4_round_ctrl.md
Name: sm4_round_ctrl

Overview:
- Sequencer for an iterative (single-round) SM4 engine.
- Accepts a master-key load, runs the 32-round key expansion on the shared datapath, and stores the 32 round keys locally.
- Then runs 32-round encrypt or decrypt jobs, feeding round keys in forward or reverse order.
- Sits between the host request interface and the round-function datapath. The datapath holds the data/key registers; this block owns sequencing, round-key storage and the handshakes.

Parameters:
- ROUNDS, 32, number of SM4 rounds; the counter width is clog2(ROUNDS).
- RKW, 32, round-key width in bits.

Ports:
- CLK_i  in  1  clock, all logic on the rising edge.
- RST_i  in  1  asynchronous, active-high reset.
- MK_VALID_i  in  1  master-key load request; the key itself is routed to the datapath.
- MK_READY_o  out  1  key request accepted on the cycle VALID&READY.
- DAT_VALID_i  in  1  block-process request.
- DEC_i  in  1  sampled with the DAT handshake: 1 = decrypt, 0 = encrypt.
- DAT_READY_o  out  1  data request accepted on the cycle VALID&READY.
- RES_VALID_o  out  1  datapath result is valid.
- RES_READY_i  in  1  consumer accepts the result.
- KEY_VALID_o  out  1  the round-key store holds a complete schedule.
- KEY_LOAD_o  out  1  datapath latches MK xor FK.
- KEY_STEP_o  out  1  datapath performs one key-expansion round.
- RK_i  in  RKW  round key from the datapath; valid while KEY_STEP_o=1.
- DAT_LOAD_o  out  1  datapath latches the input block.
- DAT_STEP_o  out  1  datapath performs one cipher round using RK_o.
- DAT_FINAL_o  out  1  datapath applies reverse transform R and registers the result.
- RK_o  out  RKW  round key for the current cipher round.
- ROUND_o  out  clog2(ROUNDS)  current round index (datapath selects CK from it).

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; round counter 0; KEY_VALID_o=0.
  - The round-key store contents are not reset.
- FSM states: IDLE, KEXP, DRUN, DFIN, HOLD.
- IDLE:
  - MK_READY_o=1.
  - DAT_READY_o = KEY_VALID_o & ~MK_VALID_i (MK wins on a simultaneous request).
- MK accept at cycle T:
  - KEY_LOAD_o=1 at T; KEY_VALID_o cleared at T+1.
  - Go to KEXP with counter=0.
- KEXP:
  - KEY_STEP_o=1, ROUND_o=counter, and RK_i is written to store[counter] every cycle.
  - After ROUNDS cycles (T+1..T+32), go to IDLE with KEY_VALID_o=1 from T+33.
- DAT accept at cycle T:
  - DAT_LOAD_o=1 at T; DEC_i is latched.
  - Go to DRUN with counter=0.
- DRUN:
  - DAT_STEP_o=1 and ROUND_o=counter.
  - RK_o = store[counter] when encrypting, store[ROUNDS-1-counter] when decrypting (combinational read).
  - Lasts ROUNDS cycles (T+1..T+32), then DFIN.
- DFIN: DAT_FINAL_o=1 for one cycle (T+33), then HOLD.
- HOLD:
  - RES_VALID_o=1 from T+34 until RES_READY_i.
  - Return to IDLE on the cycle after the handshake.
  - RES_VALID_o must not drop without RES_READY_i.
- Load latency: 34 cycles from DAT accept to RES_VALID_o with RES_READY_i held high; back-to-back throughput is one block per 35 cycles.
- Request acceptance: no request is accepted outside IDLE; both READY outputs are 0 in KEXP, DRUN, DFIN and HOLD.
- A DAT request with KEY_VALID_o=0 stalls (no accept) indefinitely.
- RK_o is 0 outside DRUN.
- Only one strobe among KEY_LOAD_o, KEY_STEP_o, DAT_LOAD_o, DAT_STEP_o and DAT_FINAL_o is high in any cycle.
- ROUND_o is 0 outside KEXP and DRUN.
- Counter wraps exactly at ROUNDS-1 → 0 with the state change; there is no extra cycle.
- RST_i asserted mid-operation: immediate return to IDLE with KEY_VALID_o=0; any partial schedule is discarded.
- New MK accepted while a key is valid: the old schedule is invalid from T+1; no DAT is accepted until the expansion completes.

Decomposition:
- Package sm4_pkg: state enum, ROUNDS, RKW, counter width, FK0..FK3 constants (shared with the datapath).
- Sub-module sm4_rk_store:
  - 32xRKW register file.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr → rdata).
  - No reset.

Test Plan:
- Reset then DAT_VALID_i=1 with no key → DAT_READY_o stays 0 for 100 cycles; all strobes 0.
- MK request at T with RK_i=0x1000+round → KEY_STEP_o high for T+1..T+32; KEY_VALID_o=1 at T+33; store[k]=0x1000+k.
- Encrypt request at T → DAT_STEP_o T+1..T+32 with RK_o=0x1000,0x1001..0x101F; DAT_FINAL_o at T+33; RES_VALID_o at T+34.
- Decrypt request with RES_READY_i low for 5 cycles → RK_o sequence 0x101F..0x1000; RES_VALID_o held 5 cycles; IDLE after the handshake.
- MK_VALID_i and DAT_VALID_i both high in IDLE → MK accepted, DAT_READY_o=0; DAT accepted only after the new KEY_VALID_o.
- RST_i pulsed at round 10 of KEXP → all outputs 0 asynchronously; KEY_VALID_o=0; a following DAT request is refused.
